// File: rtl/mdio_pkg.sv
// mdio_pkg: Clause-22 MDIO frame constants, field widths, bit indices and FSM state encoding
package mdio_pkg;
    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int DATA_W  = 16;
    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [6:0] BIT_HDR  = 7'd32;
    localparam logic [6:0] BIT_TA0  = 7'd46;
    localparam logic [6:0] BIT_TA1  = 7'd47;
    localparam logic [6:0] BIT_DATA = 7'd48;
    localparam logic [6:0] BIT_END  = 7'd64;
    typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_t;
    // Frame phase that owns frame bit n
    function automatic state_t bit_state(input logic [6:0] n);
        return n < BIT_HDR ? PRE : n < BIT_TA0 ? HDR : n < BIT_DATA ? TA : DATA;
    endfunction
endpackage

// File: rtl/mdio_master_if.sv
// mdio_master_if: request/response bus of the MDIO master
//   master modport: the mdio_master itself (consumes requests, produces responses)
//   slave modport : the client issuing register accesses
interface mdio_master_if;
    import mdio_pkg::*;
    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [PHYAD_W-1:0] req_phyad;
    logic [REGAD_W-1:0] req_regad;
    logic [DATA_W-1:0]  req_wdata;
    logic               rsp_valid;
    logic [DATA_W-1:0]  rsp_rdata;
    logic               rsp_err;
    modport master (
        input  req_valid, req_write, req_phyad, req_regad, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        output req_valid, req_write, req_phyad, req_regad, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mdio_master_mdc_gen.sv
// mdc_gen: MDC half-period counter with per-bit start/end strobes, held at zero while en_i is low
//   clk_50, reset_n : clock, synchronous active-low reset
//   en_i            : master is inside a frame
//   mdc_o           : registered MDC, low for the first DIV cycles of a bit, high for the last DIV
//   bit_start_o     : first cycle of a bit
//   bit_end_o       : last cycle of a bit
module mdc_gen #(
    parameter int DIV = 10
) (
    input  logic clk_50,
    input  logic reset_n,
    input  logic en_i,
    output logic mdc_o,
    output logic bit_start_o,
    output logic bit_end_o
);
    localparam int CW = $clog2(2 * DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mdc_q;
    always_comb cnt_d = (!en_i || cnt_q == CW'(2 * DIV - 1)) ? '0 : cnt_q + CW'(1);
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mdc_q <= cnt_d >= CW'(DIV);
        end
    end
    assign mdc_o       = mdc_q;
    assign bit_start_o = en_i && cnt_q == '0;
    assign bit_end_o   = en_i && cnt_q == CW'(2 * DIV - 1);
endmodule

// File: rtl/mdio_master.sv
// mdio_master: Clause-22 MIIM management master issuing single read/write frames
//   clk_50, reset_n : clock, synchronous active-low reset
//   phy_ready       : strap configuration done; gates new accepts only
//   bus             : request/response handshake (mdio_master_if.master)
//   mdc             : management clock, period 2*DIV, idles low
//   mdio_o, mdio_oe : MDIO drive value / enable (0 = released)
//   mdio_i          : MDIO pin, asynchronous
//   MDIO_SHORT_PREAMBLE_EN: when defined the 32-bit preamble is skipped
module mdio_master
    import mdio_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic          clk_50,
    input  logic          reset_n,
    input  logic          phy_ready,
    mdio_master_if.master bus,
    output logic          mdc,
    output logic          mdio_o,
    output logic          mdio_oe,
    input  logic          mdio_i
);
`ifdef MDIO_SHORT_PREAMBLE_EN
    localparam logic [6:0] FIRST_BIT = BIT_HDR;
`else
    localparam logic [6:0] FIRST_BIT = 7'd0;
`endif
    state_t            state_q;
    logic              rdy_q, wr_q, err_q, valid_q, mdio_o_q, mdio_oe_q;
    logic [15:0]       hdr_q;
    logic [DATA_W-1:0] data_q, rdata_q;
    logic [6:0]        bit_q, bit_d;
    logic [1:0]        sync_q;
    logic [3:0]        hidx;
    logic              in_frame, accept, bit_start, bit_end, nxt_oe, nxt_o, mdio_s;

    assign in_frame      = state_q != IDLE && state_q != DONE;
    assign bus.req_ready = rdy_q && phy_ready;
    assign accept        = bus.req_valid && bus.req_ready;
    assign mdio_s        = sync_q[1];

    mdc_gen #(.DIV(DIV)) u_mdc_gen (
        .clk_50      (clk_50),
        .reset_n     (reset_n),
        .en_i        (in_frame),
        .mdc_o       (mdc),
        .bit_start_o (bit_start),
        .bit_end_o   (bit_end)
    );

    // Drive for the bit about to start; hdr_q carries ST, OP, PHYAD, REGAD and the write TA pair
    always_comb begin
        bit_d  = bit_q + 7'd1;
        hidx   = 4'(7'd47 - bit_d);
        nxt_oe = bit_d < BIT_TA0 || wr_q;
        nxt_o  = !nxt_oe || bit_d < BIT_HDR ? 1'b1 : bit_d < BIT_DATA ? hdr_q[hidx] : data_q[DATA_W-1];
    end

    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rdy_q     <= 1'b0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            mdio_o_q  <= 1'b1;
            mdio_oe_q <= 1'b0;
            hdr_q     <= '0;
            data_q    <= '0;
            rdata_q   <= '0;
            bit_q     <= '0;
            sync_q    <= 2'b11;
        end else begin
            sync_q  <= {sync_q[0], mdio_i};
            valid_q <= 1'b0;
            if (state_q == IDLE) begin
                rdy_q <= !accept;
                if (accept) begin
                    state_q   <= bit_state(FIRST_BIT);
                    bit_q     <= FIRST_BIT;
                    wr_q      <= bus.req_write;
                    err_q     <= 1'b0;
                    hdr_q     <= {MDIO_ST, bus.req_write ? MDIO_OP_WR : MDIO_OP_RD, bus.req_phyad, bus.req_regad, 2'b10};
                    data_q    <= bus.req_wdata;
                    mdio_oe_q <= 1'b1;
                    mdio_o_q  <= FIRST_BIT < BIT_HDR ? 1'b1 : MDIO_ST[1];
                end
            end else if (state_q == DONE) begin
                state_q <= IDLE;
                rdy_q   <= 1'b1;
            end else begin
                // Write data advances on the falling side so data_q[15] is always the next bit to send
                if (bit_start && wr_q && bit_q >= BIT_DATA)
                    data_q <= {data_q[DATA_W-2:0], 1'b0};
                if (bit_end) begin
                    if (!wr_q && bit_q >= BIT_DATA)
                        data_q <= {data_q[DATA_W-2:0], mdio_s};
                    if (!wr_q && bit_q == BIT_TA1)
                        err_q <= mdio_s;
                    bit_q <= bit_d;
                    if (bit_d == BIT_END) begin
                        state_q   <= DONE;
                        valid_q   <= 1'b1;
                        mdio_oe_q <= 1'b0;
                        mdio_o_q  <= 1'b1;
                        if (!wr_q)
                            rdata_q <= {data_q[DATA_W-2:0], mdio_s};
                    end else begin
                        state_q   <= bit_state(bit_d);
                        mdio_oe_q <= nxt_oe;
                        mdio_o_q  <= nxt_o;
                    end
                end
            end
        end
    end

    assign bus.rsp_valid = valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign mdio_o        = mdio_o_q;
    assign mdio_oe       = mdio_oe_q;
endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: randomized self-checking bench for mdio_master with a frame-level PHY model
//   Honours MDIO_SHORT_PREAMBLE_EN to match a short-preamble build of the design.
module tb_mdio_master;
    localparam int DIV = 10;
    localparam int HB  = 2 * DIV;
`ifdef MDIO_SHORT_PREAMBLE_EN
    localparam int FIRST = 32;
`else
    localparam int FIRST = 0;
`endif
    localparam int NB = 64 - FIRST;

    logic clk_50 = 1'b0;
    logic reset_n = 1'b0;
    logic phy_ready = 1'b0;
    logic mdio_i = 1'b1;
    logic mdc, mdio_o, mdio_oe;
    int n_chk = 0;
    int n_err = 0;
    logic [15:0] last_rdata = 16'h0;

    mdio_master_if bus ();

    mdio_master #(.DIV(DIV)) dut (
        .clk_50    (clk_50),
        .reset_n   (reset_n),
        .phy_ready (phy_ready),
        .bus       (bus),
        .mdc       (mdc),
        .mdio_o    (mdio_o),
        .mdio_oe   (mdio_oe),
        .mdio_i    (mdio_i)
    );

    always #10 clk_50 = ~clk_50;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic wr, input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_phyad = pa;
        bus.req_regad = ra;
        bus.req_wdata = wd;
    endtask

    // Called just after a negedge; returns just after the negedge following rsp_valid
    task automatic run_frame(input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                             input logic [15:0] wd, input logic resp, input logic [15:0] rd, input int drop_at);
        logic [63:0] frame, got, mask;
        logic oe45, oe46;
        int bad;
        int k, off;
        bad   = 0;
        got   = '0;
        oe45  = 1'b0;
        oe46  = 1'b1;
        frame = {32'hFFFF_FFFF, 2'b01, wr ? 2'b01 : 2'b10, pa, ra, 2'b10, wd};
        mask  = (wr ? ~64'h0 : ~64'h3FFFF) & (~64'h0 >> FIRST);
        drive_req(wr, pa, ra, wd);
        #1;
        chk("ready_before_accept", bus.req_ready, 1);
        @(posedge clk_50);
        @(negedge clk_50);
        bus.req_valid = 1'b0;
        drive_req(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
        bus.req_valid = 1'b0;
        for (int c = 0; c < NB * HB; c++) begin
            k   = FIRST + c / HB;
            off = c % HB;
            if (mdc !== (off >= DIV)) bad++;
            if (mdio_oe !== (wr || k < 46)) bad++;
            if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) bad++;
            if (off == DIV) got[63 - k] = mdio_o;
            if (k == 45 && off == HB - 1) oe45 = mdio_oe;
            if (k == 46 && off == 0) oe46 = mdio_oe;
            if (c == drop_at) phy_ready = 1'b0;
            if (off == 0)
                mdio_i = (!wr && resp && k == 47) ? 1'b0 : (!wr && resp && k >= 48) ? rd[63 - k] : 1'b1;
            @(negedge clk_50);
        end
        mdio_i = 1'b1;
        chk("frame_bits", got & mask, frame & mask);
        chk("frame_timing", bad, 0);
        chk("rsp_valid_at_end", bus.rsp_valid, 1);
        chk("done_bus", {mdio_oe, mdio_o, mdc, bus.req_ready}, 4'b0100);
        if (!wr) begin
            last_rdata = resp ? rd : 16'hFFFF;
            chk("rsp_err", bus.rsp_err, !resp);
            chk("oe_drop_bit46", {oe45, oe46}, 2'b10);
        end
        chk("rsp_rdata", bus.rsp_rdata, last_rdata);
        @(negedge clk_50);
        chk("rsp_pulse_one_cycle", bus.rsp_valid, 0);
        chk("ready_after_done", bus.req_ready, phy_ready);
        phy_ready = 1'b1;
    endtask

    initial begin
        int bad;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_phyad = '0;
        bus.req_regad = '0;
        bus.req_wdata = '0;
        phy_ready = 1'b1;
        repeat (3) @(negedge clk_50);
        chk("reset_outputs", {mdc, mdio_o, mdio_oe, bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata},
            {6'b010000, 16'h0});
        reset_n = 1'b1;
        @(negedge clk_50);

        run_frame(1'b1, 5'd1, 5'h1F, 16'hA5C3, 1'b0, 16'h0, -1);
        run_frame(1'b0, 5'd3, 5'd2, 16'h0, 1'b1, 16'h1234, -1);
        run_frame(1'b0, 5'd7, 5'd1, 16'h0, 1'b0, 16'h0, -1);

        phy_ready = 1'b0;
        drive_req(1'b1, 5'd2, 5'd4, 16'h0F0F);
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk_50);
            if (bus.req_ready !== 1'b0 || mdc !== 1'b0 || mdio_oe !== 1'b0) bad++;
        end
        chk("blocked_by_phy_ready", bad, 0);
        phy_ready = 1'b1;
        run_frame(1'b1, 5'd2, 5'd4, 16'h0F0F, 1'b0, 16'h0, -1);

        for (int i = 0; i < 8; i++) begin
            logic wr, resp;
            logic [4:0] pa, ra;
            logic [15:0] wd, rd;
            int drop;
            wr   = 1'($urandom);
            resp = $urandom_range(0, 3) != 0;
            pa   = 5'($urandom);
            ra   = 5'($urandom);
            wd   = 16'($urandom);
            rd   = 16'($urandom);
            drop = $urandom_range(0, 1) != 0 ? int'($urandom_range(0, NB * HB - 1)) : -1;
            run_frame(wr, pa, ra, wd, resp, rd, drop);
        end

        drive_req(1'b1, 5'd5, 5'd9, 16'hFFFF);
        #1;
        chk("ready_before_reset_frame", bus.req_ready, 1);
        @(posedge clk_50);
        @(negedge clk_50);
        bus.req_valid = 1'b0;
        repeat (((NB / 3) * HB) + 5) @(negedge clk_50);
        reset_n = 1'b0;
        @(negedge clk_50);
        chk("midframe_reset_bus", {mdio_oe, mdc, bus.req_ready, bus.rsp_valid, mdio_o}, 5'b00001);
        chk("midframe_reset_rsp", {bus.rsp_rdata, bus.rsp_err}, 17'h0);
        last_rdata = 16'h0;
        repeat (3) @(negedge clk_50);
        reset_n = 1'b1;
        bad = 0;
        for (int c = 0; c < NB * HB + 100; c++) begin
            @(negedge clk_50);
            if (bus.rsp_valid !== 1'b0 || mdio_oe !== 1'b0 || mdc !== 1'b0) bad++;
        end
        chk("no_rsp_after_reset", bad, 0);

        run_frame(1'b0, 5'd1, 5'd0, 16'h0, 1'b1, 16'hBEEF, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
